// File: rtl/hyperbus_cfg_loader.sv
// hyperbus_cfg_loader: walks a table of {addr, data, mask} entries after a start
// pulse and programs them over a simple reg_req/reg_rsp bus. Each entry can be
// read back and compared under its mask. A load is aborted on a bus error, a
// read-back mismatch, or a request that waits too long for ready.
//
// Bus packing (flattened so the ports stay plain logic vectors):
//   reg_req_o = {addr, write, wdata, wstrb, valid}
//   reg_rsp_i = {rdata, error, ready}
module hyperbus_cfg_loader #(
    parameter int NumEntries    = 8,
    parameter int RegAddrWidth  = 32,
    parameter int RegDataWidth  = 32,
    parameter int VerifyWrites  = 1,
    parameter int TimeoutCycles = 1024,
    localparam int CntW  = $clog2(NumEntries + 1),
    localparam int IdxW  = (NumEntries > 1) ? $clog2(NumEntries) : 1,
    localparam int StrbW = RegDataWidth / 8,
    localparam int ReqW  = RegAddrWidth + 1 + RegDataWidth + StrbW + 1,
    localparam int RspW  = RegDataWidth + 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [CntW-1:0]                      num_entries_i,
    input  logic [NumEntries*RegAddrWidth-1:0]   entry_addr_i,
    input  logic [NumEntries*RegDataWidth-1:0]   entry_data_i,
    input  logic [NumEntries*RegDataWidth-1:0]   entry_mask_i,
    output logic [ReqW-1:0]                      reg_req_o,
    input  logic [RspW-1:0]                      reg_rsp_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [1:0]                           err_code_o,
    output logic [IdxW-1:0]                      err_idx_o
);

    localparam int WaitW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_BUS      = 2'd1;
    localparam logic [1:0] CODE_MISMATCH = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CntW-1:0]   count_r, count_s;
    logic [IdxW-1:0]   idx_r, idx_s;
    logic [WaitW-1:0]  wait_r, wait_s;
    logic              error_r, error_s;
    logic [1:0]        code_r, code_s;
    logic [IdxW-1:0]   eidx_r, eidx_s;

    logic                    rsp_ready_s;
    logic                    rsp_error_s;
    logic [RegDataWidth-1:0] rsp_rdata_s;
    logic [RegAddrWidth-1:0] cur_addr_s;
    logic [RegDataWidth-1:0] cur_data_s;
    logic [RegDataWidth-1:0] cur_mask_s;
    logic [CntW-1:0]         num_clamped_s;
    logic                    last_s;

    // Any bit that differs between read-back and expected under the mask.
    function automatic logic readback_mismatch(input logic [RegDataWidth-1:0] rdata,
                                               input logic [RegDataWidth-1:0] expected,
                                               input logic [RegDataWidth-1:0] mask);
        return |((rdata ^ expected) & mask);
    endfunction

    assign rsp_ready_s   = reg_rsp_i[0];
    assign rsp_error_s   = reg_rsp_i[1];
    assign rsp_rdata_s   = reg_rsp_i[RspW-1:2];
    assign cur_addr_s    = entry_addr_i[int'(idx_r) * RegAddrWidth +: RegAddrWidth];
    assign cur_data_s    = entry_data_i[int'(idx_r) * RegDataWidth +: RegDataWidth];
    assign cur_mask_s    = entry_mask_i[int'(idx_r) * RegDataWidth +: RegDataWidth];
    assign num_clamped_s = (num_entries_i > CntW'(NumEntries)) ? CntW'(NumEntries) : num_entries_i;
    assign last_s        = ((CntW'(idx_r) + CntW'(1)) == count_r);

    // State and bookkeeping registers; async reset abandons any load in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
            count_r <= '0;
            idx_r   <= '0;
            wait_r  <= '0;
            error_r <= 1'b0;
            code_r  <= CODE_NONE;
            eidx_r  <= '0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            idx_r   <= idx_s;
            wait_r  <= wait_s;
            error_r <= error_s;
            code_r  <= code_s;
            eidx_r  <= eidx_s;
        end
    end

    // Next-state logic: handshake on valid&ready, abort on error/mismatch/timeout.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        idx_s   = idx_r;
        wait_s  = wait_r;
        error_s = error_r;
        code_s  = code_r;
        eidx_s  = eidx_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    count_s = num_clamped_s;
                    idx_s   = '0;
                    wait_s  = '0;
                    error_s = 1'b0;
                    code_s  = CODE_NONE;
                    eidx_s  = '0;
                    state_s = (num_clamped_s == '0) ? S_DONE : S_WRITE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WRITE, S_READ: begin
                if (rsp_ready_s) begin
                    // Every accepted request starts a fresh wait window for the next one.
                    wait_s = '0;
                    if (rsp_error_s) begin
                        state_s = S_DONE;
                        error_s = 1'b1;
                        code_s  = CODE_BUS;
                        eidx_s  = idx_r;
                    end else if ((state_r == S_WRITE) && (VerifyWrites != 0)) begin
                        state_s = S_READ;
                    end else if ((state_r == S_READ) &&
                                 readback_mismatch(rsp_rdata_s, cur_data_s, cur_mask_s)) begin
                        state_s = S_DONE;
                        error_s = 1'b1;
                        code_s  = CODE_MISMATCH;
                        eidx_s  = idx_r;
                    end else if (last_s) begin
                        state_s = S_DONE;
                    end else begin
                        idx_s   = idx_r + IdxW'(1);
                        state_s = S_WRITE;
                    end
                end else if (wait_r == WaitW'(TimeoutCycles - 1)) begin
                    state_s = S_DONE;
                    error_s = 1'b1;
                    code_s  = CODE_TIMEOUT;
                    eidx_s  = idx_r;
                end else begin
                    wait_s = wait_r + WaitW'(1);
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Request bus is a pure decode of the registered state and index; zero when idle.
    always_comb begin
        reg_req_o = '0;
        if (state_r == S_WRITE) begin
            reg_req_o = {cur_addr_s, 1'b1, cur_data_s, {StrbW{1'b1}}, 1'b1};
        end else if (state_r == S_READ) begin
            reg_req_o = {cur_addr_s, 1'b0, {RegDataWidth{1'b0}}, {StrbW{1'b0}}, 1'b1};
        end else begin
            reg_req_o = '0;
        end
    end

    assign busy_o     = (state_r == S_WRITE) || (state_r == S_READ);
    assign done_o     = (state_r == S_DONE);
    assign error_o    = error_r;
    assign err_code_o = code_r;
    assign err_idx_o  = eidx_r;

endmodule
